// File: rtl/bus_arbiter_if.sv
// Bus bundle for the two-requester arbiter: instruction side, data side,
// the shared memory port and the abort indication.
interface bus_arbiter_if;
    logic        i_valid;
    logic        i_instr;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [3:0]  i_wstrb;
    logic [31:0] i_rdata;
    logic        i_ready;

    logic        d_valid;
    logic        d_instr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] d_rdata;
    logic        d_ready;

    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    logic        bus_error;

    // Arbiter view
    modport slave (
        input  i_valid, i_instr, i_addr, i_wdata, i_wstrb,
        output i_rdata, i_ready,
        input  d_valid, d_instr, d_addr, d_wdata, d_wstrb,
        output d_rdata, d_ready,
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_ready,
        output bus_error
    );

    // Environment view: requesters plus memory
    modport master (
        output i_valid, i_instr, i_addr, i_wdata, i_wstrb,
        input  i_rdata, i_ready,
        output d_valid, d_instr, d_addr, d_wdata, d_wstrb,
        input  d_rdata, d_ready,
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_ready,
        input  bus_error
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter between an instruction and a data requester onto one
// memory port. Request fields are latched at grant so the memory sees a
// stable transaction; a wait counter aborts a stalled transaction with a
// one-cycle bus_error and a zero read-data return.
module bus_arbiter #(
    parameter int TIMEOUT = 256
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_t      state_r;
    logic        last_grant_r;   // 0 = instr won last, 1 = data won last
    logic [15:0] wait_cnt_r;
    logic        instr_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [3:0]  wstrb_r;

    logic        busy_s;
    logic        timeout_s;
    logic        done_s;
    logic [31:0] ret_data_s;

    // Completion decode: normal return wins over a simultaneous timeout
    always_comb begin
        busy_s     = (state_r != IDLE);
        timeout_s  = busy_s && !bus.mem_ready && (wait_cnt_r == TIMEOUT_LAST) && !rst;
        done_s     = busy_s && (bus.mem_ready || timeout_s) && !rst;
        if (timeout_s) begin
            ret_data_s = 32'h0000_0000;
        end else begin
            ret_data_s = bus.mem_rdata;
        end
    end

    // Output drive: memory fields from the latch while busy, responses only to the granted side
    always_comb begin
        bus.mem_valid = 1'b0;
        bus.mem_instr = 1'b0;
        bus.mem_addr  = 32'h0000_0000;
        bus.mem_wdata = 32'h0000_0000;
        bus.mem_wstrb = 4'h0;
        bus.i_ready   = 1'b0;
        bus.i_rdata   = 32'h0000_0000;
        bus.d_ready   = 1'b0;
        bus.d_rdata   = 32'h0000_0000;
        bus.bus_error = timeout_s;
        if (busy_s) begin
            bus.mem_valid = 1'b1;
            bus.mem_instr = instr_r;
            bus.mem_addr  = addr_r;
            bus.mem_wdata = wdata_r;
            bus.mem_wstrb = wstrb_r;
        end else begin
            bus.mem_valid = 1'b0;
        end
        if (done_s && (state_r == IBUSY)) begin
            bus.i_ready = 1'b1;
            bus.i_rdata = ret_data_s;
        end else if (done_s && (state_r == DBUSY)) begin
            bus.d_ready = 1'b1;
            bus.d_rdata = ret_data_s;
        end else begin
            bus.i_ready = 1'b0;
            bus.d_ready = 1'b0;
        end
    end

    // Arbitration FSM, request latch and wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            wait_cnt_r   <= 16'd0;
            instr_r      <= 1'b0;
            addr_r       <= 32'h0000_0000;
            wdata_r      <= 32'h0000_0000;
            wstrb_r      <= 4'h0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.i_valid && (!bus.d_valid || last_grant_r)) begin
                        state_r      <= IBUSY;
                        last_grant_r <= 1'b0;
                        wait_cnt_r   <= 16'd0;
                        instr_r      <= bus.i_instr;
                        addr_r       <= bus.i_addr;
                        wdata_r      <= bus.i_wdata;
                        wstrb_r      <= bus.i_wstrb;
                    end else if (bus.d_valid) begin
                        state_r      <= DBUSY;
                        last_grant_r <= 1'b1;
                        wait_cnt_r   <= 16'd0;
                        instr_r      <= bus.d_instr;
                        addr_r       <= bus.d_addr;
                        wdata_r      <= bus.d_wdata;
                        wstrb_r      <= bus.d_wstrb;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                IBUSY, DBUSY: begin
                    if (bus.mem_ready || (wait_cnt_r == TIMEOUT_LAST)) begin
                        state_r <= IDLE;
                    end else if (wait_cnt_r != 16'hFFFF) begin
                        wait_cnt_r <= wait_cnt_r + 16'd1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 256, which is the number of busy-state cycles without mem_ready before the transaction is aborted (legal range 2..65535).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have ports i_valid (in, 1), i_instr (in, 1), i_addr (in, 32), i_wdata (in, 32), i_wstrb (in, 4), i_rdata (out, 32), i_ready (out, 1): the instruction-side requester.
REQ-005 SHALL have ports d_valid (in, 1), d_instr (in, 1), d_addr (in, 32), d_wdata (in, 32), d_wstrb (in, 4), d_rdata (out, 32), d_ready (out, 1): the data-side requester.
REQ-006 SHALL have ports mem_valid (out, 1), mem_instr (out, 1), mem_addr (out, 32), mem_wdata (out, 32), mem_wstrb (out, 4), mem_rdata (in, 32), mem_ready (in, 1): the shared slave port.
REQ-007 SHALL have port bus_error, output, 1 bit: a one-cycle pulse on timeout abort.

Function
REQ-008 SHALL implement the states IDLE, IBUSY and DBUSY, plus a 1-bit last_grant register (0=instr, 1=data) and a 16-bit wait counter.
REQ-009 In IDLE, with only i_valid=1, it SHALL latch the i_* request fields and enter IBUSY next cycle; with only d_valid=1, it SHALL latch the d_* fields and enter DBUSY.
REQ-010 In IDLE, with both valid, it SHALL grant the requester opposite to last_grant (round-robin) and latch only that requester's fields.
REQ-011 On entering IBUSY/DBUSY, last_grant SHALL update to the granted side and the wait counter SHALL clear to 0.
REQ-012 In IBUSY/DBUSY, mem_valid SHALL be 1 and mem_instr/addr/wdata/wstrb SHALL drive the latched fields, which stay stable until completion even if the requester changes or drops its inputs.
REQ-013 In IDLE, mem_valid SHALL be 0 and mem_addr/wdata/wstrb/instr SHALL be 0.
REQ-014 Arbitration latency SHALL be exactly 1 cycle: a valid sampled in IDLE at edge N gives mem_valid=1 from cycle N+1.
REQ-015 In a busy state with mem_ready=1, the granted side's ready SHALL be 1 and its rdata SHALL equal mem_rdata in that same cycle (combinational return), and the next state SHALL be IDLE.
REQ-016 The non-granted side's ready and rdata SHALL be 0 at all times; both readys and rdatas SHALL be 0 in IDLE.
REQ-017 Each granted ready SHALL pulse for exactly one cycle per transaction; requesters drop or renew valid in the cycle after ready, and the arbiter re-arbitrates in IDLE, which gives a minimum 1-cycle bubble between transactions.
REQ-018 In a busy state with mem_ready=0, the wait counter SHALL increment by 1 per cycle.
REQ-019 When the counter equals TIMEOUT-1 and mem_ready=0, the arbiter SHALL in that cycle drive the granted ready=1 with rdata=0x00000000, pulse bus_error=1, and go to IDLE next.
REQ-020 If mem_ready=1 in the same cycle the counter reaches TIMEOUT-1, it SHALL complete normally with no bus_error.
REQ-021 The wait counter SHALL NOT wrap; it holds while IDLE.
REQ-022 Write transactions (nonzero wstrb) SHALL follow the same handshake; rdata is passed through unmodified.

Reset
REQ-023 While rst=1 at a clock edge, the state SHALL go to IDLE, last_grant to 1 (so the first tie grants instr), the counter to 0 and the latched fields to 0.
REQ-024 After reset, all outputs SHALL be 0: mem_valid, mem_* fields, i_ready, d_ready, i_rdata, d_rdata and bus_error.
REQ-025 A reset asserted mid-transaction SHALL abandon it: mem_valid=0 the next cycle, no ready pulse and no bus_error for the abandoned request.

Verification
REQ-026 Single instr: i_valid=1, i_addr=0x00000100; mem_ready=1 two cycles after mem_valid with mem_rdata=0x00000013 -> mem_addr=0x00000100 for 3 cycles, i_ready=1 with i_rdata=0x00000013 for 1 cycle, d_ready=0 throughout.
REQ-027 Tie after reset: i_valid=d_valid=1, always-ready memory -> grant order instr, data, instr, data with one IDLE cycle between each.
REQ-028 Field stability: d_valid=1, d_addr=0x80000004, d_wstrb=0xF; d_addr changes to 0x0 during DBUSY -> mem_addr stays 0x80000004 until mem_ready.
REQ-029 Timeout: TIMEOUT=4, d_valid=1, mem_ready held 0 -> on the 4th busy cycle, d_ready=1, d_rdata=0, bus_error=1; mem_valid=0 on the next cycle.
REQ-030 Timeout boundary: TIMEOUT=4, mem_ready=1 on the 4th busy cycle -> normal completion, bus_error=0.
REQ-031 Reset mid-operation: rst=1 in the 2nd IBUSY cycle -> mem_valid=0 and i_ready=0 next cycle; a subsequent i/d tie grants instr first.
